// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FINISH = 2'b10
  } md_state_e;

  localparam int MD_ITER = 32;

  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply (shift-add) or restoring divide (shift-subtract) datapath.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        is_div_i,
  input  logic [31:0] acc_i,
  input  logic [31:0] mq_i,
  input  logic [31:0] m_i,
  output logic [31:0] acc_o,
  output logic [31:0] mq_o
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic        ge;

  always_comb begin
    sum    = {1'b0, acc_i} + {1'b0, m_i};
    rem_sh = {acc_i, mq_i[31]};
    ge     = (rem_sh >= {1'b0, m_i});
    acc_o  = acc_i;
    mq_o   = mq_i;
    if (is_div_i) begin
      // True difference is below the divisor, so 32-bit wraparound is exact.
      if (ge) begin
        acc_o = rem_sh[31:0] - m_i;
        mq_o  = {mq_i[30:0], 1'b1};
      end else begin
        acc_o = rem_sh[31:0];
        mq_o  = {mq_i[30:0], 1'b0};
      end
    end else begin
      if (mq_i[0]) begin
        acc_o = sum[32:1];
        mq_o  = {sum[0], mq_i[31:1]};
      end else begin
        acc_o = {1'b0, acc_i[31:1]};
        mq_o  = {acc_i[0], mq_i[31:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Signed handling of MULT/DIV is enabled by defining MULDIV_SIGNED_EN.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  input  logic        start,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  md_state_e   state_q;
  logic [4:0]  count_q;
  logic        is_div_q;
  logic        divz_q;
  logic        neg_res_q;
  logic        neg_rem_q;
  logic [31:0] a_q;
  logic [31:0] acc_q;
  logic [31:0] mq_q;
  logic [31:0] m_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        sa;
  logic        sb;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] acc_d;
  logic [31:0] mq_d;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

`ifdef MULDIV_SIGNED_EN
  assign sa = op[0] & a[31];
  assign sb = op[0] & b[31];
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign sa = 1'b0;
  assign sb = 1'b0;
`endif

  assign mag_a = md_abs(a, sa);
  assign mag_b = md_abs(b, sb);

  muldiv_step u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .mq_i     (mq_q),
    .m_i      (m_q),
    .acc_o    (acc_d),
    .mq_o     (mq_d)
  );

  always_comb begin
    prod = neg_res_q ? (~{acc_q, mq_q} + 64'd1) : {acc_q, mq_q};
    quo  = neg_res_q ? (~mq_q + 32'd1) : mq_q;
    rem  = neg_rem_q ? (~acc_q + 32'd1) : acc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      is_div_q  <= 1'b0;
      divz_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hi_we) hi_q <= wd;
          if (lo_we) lo_q <= wd;
          if (start) begin
            is_div_q  <= op[1];
            divz_q    <= (b == 32'd0);
            neg_res_q <= sa ^ sb;
            neg_rem_q <= sa;
            a_q       <= a;
            acc_q     <= '0;
            count_q   <= '0;
            // Multiply iterates over the multiplier; divide shifts the dividend out.
            mq_q      <= op[1] ? mag_a : mag_b;
            m_q       <= op[1] ? mag_b : mag_a;
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q   <= acc_d;
          mq_q    <= mq_d;
          count_q <= count_q + 5'd1;
          if (count_q == 5'(MD_ITER - 1)) state_q <= ST_FINISH;
        end
        ST_FINISH: begin
          if (!is_div_q) begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
          end else if (divz_q) begin
            hi_q <= a_q;
            lo_q <= 32'hFFFF_FFFF;
          end else begin
            hi_q <= rem;
            lo_q <= quo;
          end
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the pipelined MIPS EX stage. It implements MULT, MULTU, DIV and DIVU into the architectural HI/LO registers, and services MTHI/MTLO writes. It sits beside the single-cycle 32-bit ALU and takes the same forwarded A/B operands. Its busy flag stalls the pipeline on MFHI/MFLO while an operation is in flight.

## Interface
- No parameters; width fixed at 32.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- a  in  32  operand A; multiplicand or dividend.
- b  in  32  operand B; multiplier or divisor.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- start  in  1  launch op; sampled only in IDLE.
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wd  in  32  MTHI/MTLO write data.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when HI/LO were just updated by an op.

## Operation
- States: IDLE, RUN, FINISH, encoded as a 2-bit enum.
- IDLE with start=1:
  - capture op, sign flags and operand magnitudes;
  - clear accumulator and count;
  - go to RUN.
- Signed ops (01/11) use |a| and |b|; unsigned ops use raw operands.
- RUN, multiply: 32 shift-add steps on a 64-bit {acc, multiplier} register.
- RUN, divide: 32 restoring shift-subtract steps producing quotient and remainder.
- RUN ends when count==31; the next state is FINISH.
- FINISH writes HI/LO, pulses done and returns to IDLE.
- Multiply result: HI = product[63:32], LO = product[31:0]. MULT negates the 64-bit product when sign(a)≠sign(b).
- Divide result: LO = quotient, HI = remainder.
- DIV sign rules:
  - quotient is negated when the operand signs differ;
  - remainder takes the sign of the dividend.
- Divide by zero, any divide op: HI = a as captured (original, not magnitude), LO = 0xFFFFFFFF. The full latency is still taken.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MTHI/MTLO:
  - in IDLE, hi_we/lo_we write wd on the edge;
  - while busy they are ignored;
  - on the FINISH edge the op result wins.
- start while busy is ignored. start is not queued.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, count=0.
- start sampled at edge E0.
- Edges E1..E32 perform iterations 0..31.
- E33 (FINISH) updates HI/LO; done=1 for the cycle after E33.
- busy is high from after E0 through E33: 33 cycles. busy is a registered output: busy = (state≠IDLE).
- done and busy are never high together.
- In the done-high cycle the state is IDLE, so a new start is accepted (back-to-back ops every 34 cycles).
- Operands a/b/op may change after E0; they are not sampled again.
- Reset asserted mid-op aborts immediately to IDLE with hi=lo=0 and no done pulse.

## Configuration
- MULDIV_SIGNED_EN defined: MULT and DIV perform the signed handling above.
- Undefined: the sign-capture and negation logic is removed, op[0] is ignored, and MULT/DIV behave exactly as MULTU/DIVU.
- Latency is identical either way.

## Structure
- Shared package muldiv_pkg holds:
  - the op enum (MD_MULTU, MD_MULT, MD_DIVU, MD_DIV);
  - the state enum;
  - constant MD_ITER = 32.
- One sub-module is natural: muldiv_step. It is the combinational single-iteration datapath (shift-add or shift-subtract selected by a multiply/divide flag). It is instanced once and the top level holds the registers and FSM.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after E33: HI=0xFFFFFFFE, LO=0x00000001; busy high 33 cycles; done one cycle.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. With MULDIV_SIGNED_EN undefined: HI=0x00000006, LO=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU a=0x12345678, b=0 -> HI=0x12345678, LO=0xFFFFFFFF after full latency.
- Handshake:
  - a start pulse at mid-RUN is ignored;
  - hi_we while busy is ignored;
  - start in the done cycle launches a second op, whose result appears 34 cycles after the first.
- Reset asserted at iteration 10 -> hi=lo=0, busy=0 immediately; no done. MTLO wd=0xA5A5A5A5 in IDLE -> lo=0xA5A5A5A5 next cycle.
